mine_count_engine: RTL
======================

MINE_COUNT_ENGINE -- requirements
Module: mine_count_engine

Interface
REQ-001 in_clka  input  1  clock; all state updates on rising edge.
REQ-002 in_rst_n  input  1  asynchronous active-low reset.
REQ-003 in_start  input  1  request to capture and process a mine map; sampled only in IDLE.
REQ-004 in_mines  input  25  mine map from RNG; bit i = cell i, row = i/5, col = i%5; 1 = mine.
REQ-005 in_rd_idx  input  5  read index for result port; values 25..31 are invalid.
REQ-006 out_busy  output  1  high from the cycle after start capture through the last SCAN cycle.
REQ-007 out_done  output  1  single-cycle pulse when all 25 counts are valid.
REQ-008 out_rd_count  output  4  stored neighbour count of cell in_rd_idx (0..8); 0 for invalid index.
REQ-009 out_rd_mine  output  1  captured mine bit of cell in_rd_idx; 0 for invalid index.
REQ-010 out_mine_total  output  5  population count of captured map (0..25).

Function
REQ-011 FSM states IDLE, SCAN, DONE; IDLE->SCAN on in_start=1; SCAN->DONE after index 24 is processed; DONE->IDLE unconditionally after one cycle.
REQ-012 On the start edge: in_mines is copied into an internal map register, scan index is cleared to 0, all 25 counts are cleared, and out_mine_total is cleared.
REQ-013 SCAN processes exactly one cell per cycle, index 0..24 ascending; exactly 25 SCAN cycles.
REQ-014 Count(i) = number of mine bits among the up-to-8 orthogonal/diagonal neighbours inside the 5x5 grid; no wrap-around at edges; cell i itself excluded.
REQ-015 Counts are computed for mine cells as well as non-mine cells.
REQ-016 out_mine_total accumulates by +1 for each mine cell scanned; final value is valid with out_done.
REQ-017 Timing: start sampled at edge 0; SCAN at edges 1..25; out_done=1 during the cycle after edge 26; out_busy=0 in that cycle.
REQ-018 in_start is ignored in SCAN and DONE; in_mines changes after capture have no effect on the result.
REQ-019 in_start in IDLE after a completed run restarts processing and overwrites all previous results.
REQ-020 out_rd_count and out_rd_mine are combinational from stored state and in_rd_idx; they are valid for reads at any time and hold results until the next start or reset.
REQ-021 Count storage is 25 x 4-bit registers; the adder is at most 4 bits wide with no overflow (max 8).

Reset
REQ-022 in_rst_n=0 forces IDLE immediately, regardless of clock.
REQ-023 Reset values: map=0, all counts=0, scan index=0, out_busy=0, out_done=0, out_mine_total=0; out_rd_count=0 and out_rd_mine=0 follow.
REQ-024 Reset during SCAN abandons the run; no out_done is produced; the first in_start after release behaves as a fresh run.

Configuration
REQ-025 Macro MINE_COUNT_ZERO_MAP_EN defined: adds output out_zero_map [24:0]; bit i=1 iff cell i is not a mine and Count(i)=0; the map is registered, updated per cell during SCAN, cleared at start and reset, and valid with out_done.
REQ-026 Macro MINE_COUNT_ZERO_MAP_EN undefined: port and logic are absent; all other behaviour is identical.

Verification
REQ-027 in_mines=25'h0000001 -> counts for cells 1, 5 and 6 are 1, all other cells 0, out_mine_total=1, out_done exactly 26 cycles after the start edge, out_busy high for 25 cycles.
REQ-028 in_mines=25'h0001000 (cell 12) -> cells 6, 7, 8, 11, 13, 16, 17 and 18 count 1, all others 0 (including cell 12), out_mine_total=1.
REQ-029 in_mines=25'h1FFFFFF -> cell 0=3, cell 2=5, cell 12=8, cell 24=3, out_mine_total=25, out_rd_mine=1 for all indices, in_rd_idx=27 gives count 0 and mine 0.
REQ-030 Start a run; at cycle 5 pulse in_start with in_mines=0 and change in_mines -> the second start is ignored and the results match the first captured map.
REQ-031 Assert in_rst_n=0 asynchronously at SCAN cycle 10 -> out_busy=0 immediately, all counts=0, no out_done; a restart with 25'h0000001 reproduces the REQ-027 results.
REQ-032 With MINE_COUNT_ZERO_MAP_EN defined, in_mines=25'h0000001 -> out_zero_map=25'h1FFFF9C at out_done.

Source files
------------

// File: rtl/mine_count_engine.sv
// -----------------------------------------------------------------------------
// mine_count_engine
//   Captures a 5x5 mine map and walks it one cell per cycle, storing for every
//   cell the number of mines among its (up to 8) in-grid neighbours, plus a
//   running population count of the captured map.
//
//   Build option: define MINE_COUNT_ZERO_MAP_EN to add out_zero_map, a
//   registered flag per cell set when the cell is empty and has no
//   neighbouring mines.
//
// Ports
//   in_clka        clock, rising edge
//   in_rst_n       asynchronous active-low reset
//   in_start       capture in_mines and start a scan (only honoured in IDLE)
//   in_mines[24:0] mine map, bit i = cell i (row i/5, col i%5)
//   in_rd_idx[4:0] result read index, 25..31 read as zero
//   out_busy       high while scanning
//   out_done       one-cycle pulse when all counts are valid
//   out_rd_count   neighbour count of cell in_rd_idx
//   out_rd_mine    captured mine bit of cell in_rd_idx
//   out_mine_total mines in the captured map
//   out_zero_map   (optional) empty, zero-neighbour cells
// -----------------------------------------------------------------------------
module mine_count_engine (
  input  logic        in_clka,
  input  logic        in_rst_n,
  input  logic        in_start,
  input  logic [24:0] in_mines,
  input  logic [4:0]  in_rd_idx,
  output logic        out_busy,
  output logic        out_done,
  output logic [3:0]  out_rd_count,
  output logic        out_rd_mine,
`ifdef MINE_COUNT_ZERO_MAP_EN
  output logic [24:0] out_zero_map,
`endif
  output logic [4:0]  out_mine_total
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [24:0]      r_map;
  logic [4:0]       r_idx;
  logic [24:0][3:0] r_cnt;
  logic [4:0]       r_total;
  logic             r_done;
  logic [2:0]       w_row, w_col;
  logic [3:0]       w_nbr;
`ifdef MINE_COUNT_ZERO_MAP_EN
  logic [24:0]      r_zero;
`endif

  // Row/column of the cell being scanned
  always_comb begin
    w_row = 3'(r_idx / 5'd5);
    w_col = 3'(r_idx % 5'd5);
  end

  // Neighbour count of the current cell; out-of-grid positions are skipped,
  // so edges do not wrap. Max 8 fits in 4 bits.
  always_comb begin
    w_nbr = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) &&
            (int'(w_row) + dr) >= 0 && (int'(w_row) + dr) < 5 &&
            (int'(w_col) + dc) >= 0 && (int'(w_col) + dc) < 5) begin
          w_nbr = w_nbr + 4'(r_map[5'((int'(w_row) + dr) * 5 + int'(w_col) + dc)]);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_start)      w_state_nxt = ST_SCAN;
      ST_SCAN: if (r_idx == 5'd24) w_state_nxt = ST_DONE;
      ST_DONE:                     w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clka or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= ST_IDLE;
      r_map   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_total <= '0;
      r_done  <= 1'b0;
`ifdef MINE_COUNT_ZERO_MAP_EN
      r_zero  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      // Pulse lands one cycle after the DONE state so busy and done never overlap
      r_done  <= (r_state == ST_DONE);
      if (r_state == ST_IDLE && in_start) begin
        r_map   <= in_mines;
        r_idx   <= '0;
        r_cnt   <= '0;
        r_total <= '0;
`ifdef MINE_COUNT_ZERO_MAP_EN
        r_zero  <= '0;
`endif
      end else if (r_state == ST_SCAN) begin
        r_cnt[r_idx] <= w_nbr;
        if (r_map[r_idx]) r_total <= r_total + 5'd1;
`ifdef MINE_COUNT_ZERO_MAP_EN
        r_zero[r_idx] <= ~r_map[r_idx] & (w_nbr == 4'd0);
`endif
        if (r_idx != 5'd24) r_idx <= r_idx + 5'd1;
      end
    end
  end

  always_comb begin
    out_rd_count = '0;
    out_rd_mine  = 1'b0;
    if (in_rd_idx < 5'd25) begin
      out_rd_count = r_cnt[in_rd_idx];
      out_rd_mine  = r_map[in_rd_idx];
    end
  end

  assign out_busy       = (r_state == ST_SCAN);
  assign out_done       = r_done;
  assign out_mine_total = r_total;
`ifdef MINE_COUNT_ZERO_MAP_EN
  assign out_zero_map   = r_zero;
`endif

endmodule
